// File: rtl/rd_arbiter_2to1_if.sv
// rtl/rd_arbiter_2to1_if.sv - AXI3 read address + read data channel bundle
`timescale 1ns/1ps
interface rd_arbiter_2to1_if;
    logic [31:0] araddr;
    logic [3:0]  arid;
    logic [1:0]  arburst;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport master (
        output araddr, arid, arburst, arlen, arsize, arlock, arcache, arprot, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );

    modport slave (
        input  araddr, arid, arburst, arlen, arsize, arlock, arcache, arprot, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/rd_arbiter_2to1.sv
// rtl/rd_arbiter_2to1.sv - two-master to one-slave AXI3 read arbiter, one outstanding read
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; fixed priority (m0 first) otherwise.
`timescale 1ns/1ps
module rd_arbiter_2to1 (
    input  logic                     aclk,
    input  logic                     areset,
    rd_arbiter_2to1_if.slave         m0,
    rd_arbiter_2to1_if.slave         m1,
    rd_arbiter_2to1_if.master        s,
    output logic                     rlast_err
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       gnt_q, gnt_d;
    logic       last_gnt_q, last_gnt_d;
    logic [3:0] len_q, len_d;
    logic [3:0] beat_cnt_q, beat_cnt_d;
    logic       rlast_err_q, rlast_err_d;

    logic       pick_m1;
    logic       ar_sel_m1;
    logic       ar_valid_g;
    logic       r_ready_g;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q     <= ST_IDLE;
            gnt_q       <= 1'b0;
            last_gnt_q  <= 1'b1;
            len_q       <= 4'd0;
            beat_cnt_q  <= 4'd0;
            rlast_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_gnt_q  <= last_gnt_d;
            len_q       <= len_d;
            beat_cnt_q  <= beat_cnt_d;
            rlast_err_q <= rlast_err_d;
        end
    end

    // pick_m1 is only consulted when at least one master requests
    always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
        if (m0.arvalid && m1.arvalid) begin
            pick_m1 = ~last_gnt_q;
        end else begin
            pick_m1 = m1.arvalid;
        end
`else
        pick_m1 = ~m0.arvalid;
`endif
    end

    assign ar_sel_m1  = (state_q == ST_ADDR) && gnt_q;
    assign ar_valid_g = gnt_q ? m1.arvalid : m0.arvalid;
    assign r_ready_g  = gnt_q ? m1.rready  : m0.rready;

    assign s.araddr  = ar_sel_m1 ? m1.araddr  : m0.araddr;
    assign s.arid    = ar_sel_m1 ? m1.arid    : m0.arid;
    assign s.arburst = ar_sel_m1 ? m1.arburst : m0.arburst;
    assign s.arlen   = ar_sel_m1 ? m1.arlen   : m0.arlen;
    assign s.arsize  = ar_sel_m1 ? m1.arsize  : m0.arsize;
    assign s.arlock  = ar_sel_m1 ? m1.arlock  : m0.arlock;
    assign s.arcache = ar_sel_m1 ? m1.arcache : m0.arcache;
    assign s.arprot  = ar_sel_m1 ? m1.arprot  : m0.arprot;

    // R payload is broadcast; only the granted master sees rvalid
    assign m0.rid   = s.rid;
    assign m0.rdata = s.rdata;
    assign m0.rresp = s.rresp;
    assign m0.rlast = s.rlast;
    assign m1.rid   = s.rid;
    assign m1.rdata = s.rdata;
    assign m1.rresp = s.rresp;
    assign m1.rlast = s.rlast;

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_gnt_d  = last_gnt_q;
        len_d       = len_q;
        beat_cnt_d  = beat_cnt_q;
        rlast_err_d = rlast_err_q;
        s.arvalid   = 1'b0;
        s.rready    = 1'b0;
        m0.arready  = 1'b0;
        m1.arready  = 1'b0;
        m0.rvalid   = 1'b0;
        m1.rvalid   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (m0.arvalid || m1.arvalid) begin
                    gnt_d   = pick_m1;
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                s.arvalid = ar_valid_g;
                if (gnt_q) begin
                    m1.arready = s.arready;
                end else begin
                    m0.arready = s.arready;
                end
                if (ar_valid_g && s.arready) begin
                    len_d      = gnt_q ? m1.arlen : m0.arlen;
                    beat_cnt_d = 4'd0;
                    state_d    = ST_DATA;
                end
            end
            ST_DATA: begin
                s.rready = r_ready_g;
                if (gnt_q) begin
                    m1.rvalid = s.rvalid;
                end else begin
                    m0.rvalid = s.rvalid;
                end
                if (s.rvalid && r_ready_g) begin
                    beat_cnt_d = beat_cnt_q + 4'd1;
                    if (s.rlast) begin
                        if (beat_cnt_q != len_q) begin
                            rlast_err_d = 1'b1;
                        end
                        last_gnt_d = gnt_q;
                        state_d    = ST_IDLE;
                    end else if (beat_cnt_q == len_q) begin
                        // beat len+1 arrived without rlast: flag it, keep routing the burst
                        rlast_err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign rlast_err = rlast_err_q;
endmodule

// File: tb/tb_rd_arbiter_2to1.sv
// tb/tb_rd_arbiter_2to1.sv - randomized scoreboard bench for rd_arbiter_2to1
`timescale 1ns/1ps
module tb_rd_arbiter_2to1;
    localparam int ISSUE_LIMIT = 100;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR_EN = 1'b1;
`else
    localparam bit RR_EN = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  id;
        logic [1:0]  burst;
        logic [3:0]  len;
        logic [2:0]  size;
        logic [1:0]  lock;
        logic [3:0]  cache;
        logic [2:0]  prot;
    } ar_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  id;
        logic [1:0]  resp;
        logic        last;
        logic        err_after;
    } r_t;

    typedef struct {
        int  mst;
        ar_t ar;
    } exp_ar_t;

    logic aclk = 1'b0;
    logic areset = 1'b1;
    logic rlast_err;

    rd_arbiter_2to1_if m0_if ();
    rd_arbiter_2to1_if m1_if ();
    rd_arbiter_2to1_if s_if ();

    rd_arbiter_2to1 dut (
        .aclk      (aclk),
        .areset    (areset),
        .m0        (m0_if),
        .m1        (m1_if),
        .s         (s_if),
        .rlast_err (rlast_err)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int issued = 0;
    int done_cnt = 0;
    int cur_g = 0;
    int last_model = 1;
    bit exp_err = 1'b0;
    bit prev_r0 = 1'b0, prev_r1 = 1'b0, prev_s_arvalid = 1'b0;
    ar_t mreq [2];
    bit  mpend [2];
    exp_ar_t ar_q [$];
    r_t exp_r0 [$];
    r_t exp_r1 [$];
    r_t slave_q [$];
    exp_ar_t mon_e;
    r_t mon_x;
    int stall_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s got no-event want event (t=%0t)", name, $time);
    endtask

    function automatic int pick(input bit r0, input bit r1, input int last);
        if (r0 && r1) return RR_EN ? 1 - last : 0;
        return r0 ? 0 : 1;
    endfunction

    function automatic ar_t rand_ar();
        ar_t a;
        a.addr  = $urandom;
        a.id    = 4'($urandom);
        a.burst = 2'($urandom);
        a.len   = 4'($urandom_range(0, 7));
        a.size  = 3'($urandom);
        a.lock  = 2'($urandom);
        a.cache = 4'($urandom);
        a.prot  = 3'($urandom);
        return a;
    endfunction

    function automatic ar_t s_ar();
        ar_t a;
        a.addr  = s_if.araddr;
        a.id    = s_if.arid;
        a.burst = s_if.arburst;
        a.len   = s_if.arlen;
        a.size  = s_if.arsize;
        a.lock  = s_if.arlock;
        a.cache = s_if.arcache;
        a.prot  = s_if.arprot;
        return a;
    endfunction

    function automatic bit busy();
        return mpend[0] || mpend[1] || (slave_q.size() != 0) || (exp_r0.size() != 0) ||
               (exp_r1.size() != 0) || (ar_q.size() != 0);
    endfunction

    task automatic drive_masters();
        m0_if.araddr = mreq[0].addr;  m0_if.arid = mreq[0].id;     m0_if.arburst = mreq[0].burst;
        m0_if.arlen = mreq[0].len;    m0_if.arsize = mreq[0].size; m0_if.arlock = mreq[0].lock;
        m0_if.arcache = mreq[0].cache; m0_if.arprot = mreq[0].prot; m0_if.arvalid = mpend[0];
        m1_if.araddr = mreq[1].addr;  m1_if.arid = mreq[1].id;     m1_if.arburst = mreq[1].burst;
        m1_if.arlen = mreq[1].len;    m1_if.arsize = mreq[1].size; m1_if.arlock = mreq[1].lock;
        m1_if.arcache = mreq[1].cache; m1_if.arprot = mreq[1].prot; m1_if.arvalid = mpend[1];
    endtask

    // Slave response plan: normally len+1 beats, sometimes one short or one long
    task automatic plan_burst(input int g);
        int n, len, mode;
        r_t b;
        len  = int'(mreq[g].len);
        mode = $urandom_range(0, 9);
        n    = len + 1;
        if (mode == 0 && len > 0) n = len;
        else if (mode == 1 && len < 14) n = len + 2;
        for (int i = 0; i < n; i++) begin
            b.data      = $urandom;
            b.id        = mreq[g].id;
            b.resp      = 2'($urandom);
            b.last      = (i == n - 1);
            b.err_after = b.last ? (i != len) : (i == len);
            slave_q.push_back(b);
            if (g == 0) exp_r0.push_back(b);
            else exp_r1.push_back(b);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_arvalid_s"}, 64'(s_if.arvalid), 64'(0));
        chk({tag, "_rready_s"},  64'(s_if.rready),  64'(0));
        chk({tag, "_arready_m0"}, 64'(m0_if.arready), 64'(0));
        chk({tag, "_arready_m1"}, 64'(m1_if.arready), 64'(0));
        chk({tag, "_rvalid_m0"}, 64'(m0_if.rvalid), 64'(0));
        chk({tag, "_rvalid_m1"}, 64'(m1_if.rvalid), 64'(0));
        chk({tag, "_rlast_err"}, 64'(rlast_err), 64'(0));
    endtask

    task automatic step(input bit allow_issue);
        bit r0, r1, hs_m0, hs_m1, hs_s_ar, hs_s_r, keep_rv;
        exp_ar_t e;
        @(negedge aclk);
        r0      = m0_if.arvalid;
        r1      = m1_if.arvalid;
        hs_m0   = m0_if.arvalid && m0_if.arready;
        hs_m1   = m1_if.arvalid && m1_if.arready;
        hs_s_ar = s_if.arvalid && s_if.arready;
        hs_s_r  = s_if.rvalid && s_if.rready;
        keep_rv = s_if.rvalid && !hs_s_r;
        if (s_if.arvalid && !prev_s_arvalid) begin
            cur_g      = pick(prev_r0, prev_r1, last_model);
            last_model = cur_g;
            e.mst      = cur_g;
            e.ar       = mreq[cur_g];
            ar_q.push_back(e);
        end
        if (hs_s_ar) plan_burst(cur_g);
        prev_r0        = r0;
        prev_r1        = r1;
        prev_s_arvalid = s_if.arvalid;

        @(posedge aclk);
        #1;
        cyc++;
        if (hs_m0) mpend[0] = 1'b0;
        if (hs_m1) mpend[1] = 1'b0;
        if (hs_s_r) void'(slave_q.pop_front());
        for (int m = 0; m < 2; m++) begin
            if (allow_issue && !mpend[m] && issued < ISSUE_LIMIT && $urandom_range(0, 3) != 0) begin
                mreq[m]  = rand_ar();
                mpend[m] = 1'b1;
                issued++;
            end
        end
        drive_masters();
        if (stall_cnt > 0) begin
            s_if.arready = 1'b0;
            stall_cnt--;
        end else begin
            s_if.arready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) stall_cnt = 5;
        end
        if (keep_rv) s_if.rvalid = 1'b1;
        else s_if.rvalid = (slave_q.size() != 0) && ($urandom_range(0, 3) != 0);
        if (slave_q.size() != 0) begin
            s_if.rdata = slave_q[0].data;
            s_if.rid   = slave_q[0].id;
            s_if.rresp = slave_q[0].resp;
            s_if.rlast = slave_q[0].last;
        end
        m0_if.rready = ($urandom_range(0, 9) < 6);
        m1_if.rready = ($urandom_range(0, 9) < 6);
    endtask

    task automatic mon_r(input int m, input logic rv, input logic rr, input logic [31:0] d,
                         input logic [3:0] id, input logic [1:0] resp, input logic last);
        bit empty;
        empty = (m == 0) ? (exp_r0.size() == 0) : (exp_r1.size() == 0);
        if (rv) begin
            if (empty) begin
                fail(m == 0 ? "rvalid_m0_unexpected" : "rvalid_m1_unexpected");
            end else if (rr) begin
                mon_x = (m == 0) ? exp_r0.pop_front() : exp_r1.pop_front();
                chk("r_data", 64'(d), 64'(mon_x.data));
                chk("r_id",   64'(id), 64'(mon_x.id));
                chk("r_resp", 64'(resp), 64'(mon_x.resp));
                chk("r_last", 64'(last), 64'(mon_x.last));
                if (mon_x.last) done_cnt++;
                if (mon_x.err_after) exp_err = 1'b1;
            end
        end
    endtask

    always begin
        @(negedge aclk);
        #1;
        if (!areset) begin
            chk("rlast_err", 64'(rlast_err), 64'(exp_err));
            if (s_if.arvalid) begin
                if (ar_q.size() == 0) begin
                    fail("arvalid_s_unexpected");
                end else begin
                    mon_e = ar_q[0];
                    chk("ar_payload", 64'(s_ar()), 64'(mon_e.ar));
                    chk("ar_loser_ready", 64'(mon_e.mst == 0 ? m1_if.arready : m0_if.arready), 64'(0));
                    chk("ar_winner_ready", 64'(mon_e.mst == 0 ? m0_if.arready : m1_if.arready),
                        64'(s_if.arready));
                    if (s_if.arready) void'(ar_q.pop_front());
                end
            end
            if (s_if.rvalid) begin
                if (exp_r0.size() != 0) chk("rready_mirror_m0", 64'(s_if.rready), 64'(m0_if.rready));
                else if (exp_r1.size() != 0) chk("rready_mirror_m1", 64'(s_if.rready), 64'(m1_if.rready));
            end else if (exp_r0.size() == 0 && exp_r1.size() == 0) begin
                chk("rready_s_idle", 64'(s_if.rready), 64'(0));
            end
            mon_r(0, m0_if.rvalid, m0_if.rready, m0_if.rdata, m0_if.rid, m0_if.rresp, m0_if.rlast);
            mon_r(1, m1_if.rvalid, m1_if.rready, m1_if.rdata, m1_if.rid, m1_if.rresp, m1_if.rlast);
        end
    end

    initial begin
        mreq[0] = '0; mreq[1] = '0;
        mpend[0] = 1'b0; mpend[1] = 1'b0;
        drive_masters();
        m0_if.rready = 1'b0; m1_if.rready = 1'b0;
        s_if.arready = 1'b0; s_if.rvalid = 1'b0; s_if.rlast = 1'b0;
        s_if.rdata = '0; s_if.rid = '0; s_if.rresp = '0;
        @(posedge aclk);
        #1;
        check_outputs_zero("reset");
        repeat (2) @(posedge aclk);
        #1;
        mreq[0]      = rand_ar();
        mreq[0].addr = 32'h0000_1000;
        mreq[0].len  = 4'd3;
        mpend[0]     = 1'b1;
        issued       = 1;
        drive_masters();
        areset = 1'b0;

        while (done_cnt < 30 && cyc < 8000) step(1'b1);
        while (slave_q.size() < 2 && cyc < 9000) step(1'b1);
        if (slave_q.size() < 2) begin
            fail("reset_setup_timeout");
        end else begin
            areset = 1'b1;
            #1;
            check_outputs_zero("midburst_reset");
            slave_q.delete(); exp_r0.delete(); exp_r1.delete(); ar_q.delete();
            exp_err = 1'b0; last_model = 1;
            prev_r0 = 1'b0; prev_r1 = 1'b0; prev_s_arvalid = 1'b0; stall_cnt = 0;
            mreq[0] = rand_ar(); mreq[1] = rand_ar();
            mpend[0] = 1'b1; mpend[1] = 1'b1;
            drive_masters();
            s_if.rvalid = 1'b0; s_if.arready = 1'b1;
            repeat (2) @(posedge aclk);
            #1;
            areset = 1'b0;
        end

        while ((issued < ISSUE_LIMIT || busy()) && cyc < 30000) step(1'b1);
        if (cyc >= 30000) fail("drain_timeout");
        repeat (2) @(posedge aclk);
        chk("ar_queue_empty", 64'(ar_q.size()), 64'(0));
        chk("r_queue_m0_empty", 64'(exp_r0.size()), 64'(0));
        chk("r_queue_m1_empty", 64'(exp_r1.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
